// File: rtl/move_link_ctrl.sv
// move_link_ctrl: sequences the inter-board UART move link.
// Frames local moves as {seq, move}, waits for a matching ack and
// retransmits on timeout. Received moves are delivered once and acked.
// Acks and moves share the single tx instance through a small arbiter.
module move_link_ctrl #(
  parameter int TIMEOUT_CYC = 6_500_000,
  parameter int MAX_RETRY   = 3,
  parameter int GUARD_CYC   = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       move_valid_in,
  input  logic [6:0] move_in,
  input  logic       tx_busy_in,
  output logic       tx_trigger_out,
  output logic [7:0] tx_val_out,
  input  logic       rx_ready_in,
  input  logic [7:0] rx_data_in,
  output logic       rx_move_valid_out,
  output logic [6:0] rx_move_out,
  output logic       move_sent_out,
  output logic       link_busy_out,
  output logic       link_error_out,
  output logic [1:0] retry_count_out
);

  localparam logic [6:0] ACK_CODE = 7'h7F;
  localparam int TO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int GD_W = (GUARD_CYC < 2) ? 1 : $clog2(GUARD_CYC + 1);
  localparam logic [TO_W-1:0] TO_LOAD     = TO_W'(TIMEOUT_CYC);
  localparam logic [GD_W-1:0] GD_LOAD     = GD_W'(GUARD_CYC);
  localparam logic [1:0]      RETRY_LIMIT = 2'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, ERROR} send_state_t;

  send_state_t     state_q, state_d;
  logic [6:0]      move_q;
  logic            tx_seq_q;
  logic            last_rx_seq_q;
  logic            ack_pending_q;
  logic            ack_seq_q;
  logic [TO_W-1:0] timeout_q;
  logic [GD_W-1:0] guard_q;

  logic rx_is_ack, rx_is_move, rx_new_move;
  logic arb_free, ack_grant, send_grant;
  logic ack_match, timeout_hit, can_retry;
  logic accept_move, retry_inc;

  // Receive decode: the low seven bits distinguish acks from moves.
  assign rx_is_ack   = rx_ready_in && (rx_data_in[6:0] == ACK_CODE);
  assign rx_is_move  = rx_ready_in && (rx_data_in[6:0] != ACK_CODE);
  assign rx_new_move = rx_is_move && (rx_data_in[7] != last_rx_seq_q);

  // Arbiter: a pending ack always beats a waiting move frame.
  assign arb_free   = !tx_busy_in && (guard_q == '0);
  assign ack_grant  = arb_free && ack_pending_q;
  assign send_grant = arb_free && !ack_pending_q && (state_q == SEND);

  assign ack_match   = rx_is_ack && (rx_data_in[7] == tx_seq_q) && (state_q == WAIT_ACK);
  assign timeout_hit = (state_q == WAIT_ACK) && (timeout_q == '0);
  assign can_retry   = retry_count_out < RETRY_LIMIT;

  // Send FSM state register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Send FSM next-state logic; a valid ack outranks a same-cycle timeout.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (move_valid_in) state_d = SEND;
      SEND:     if (send_grant) state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (ack_match)        state_d = IDLE;
        else if (timeout_hit) state_d = can_retry ? SEND : ERROR;
      end
      ERROR:    state_d = ERROR;
      default:  state_d = IDLE;
    endcase
  end

  // Send FSM output decode: move capture and retry accounting strobes.
  always_comb begin
    accept_move = 1'b0;
    retry_inc   = 1'b0;
    case (state_q)
      IDLE:     accept_move = move_valid_in;
      WAIT_ACK: retry_inc   = !ack_match && timeout_hit && can_retry;
      default:  ;
    endcase
  end

  // Send-side registers: status outputs, latched move, sequence and retries.
  // NOTE: every register, outputs included, sits on the async reset so all
  // outputs read 0 the moment rst_in falls, mid-frame or not.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      move_sent_out   <= 1'b0;
      link_busy_out   <= 1'b0;
      link_error_out  <= 1'b0;
      retry_count_out <= '0;
      move_q          <= '0;
      tx_seq_q        <= 1'b0;
      timeout_q       <= '0;
    end else begin
      move_sent_out <= ack_match;
      link_busy_out <= (state_d != IDLE);
      if (state_d == ERROR) link_error_out <= 1'b1;
      if (accept_move) move_q <= move_in;
      if (ack_match) tx_seq_q <= ~tx_seq_q;
      if (state_q == IDLE) retry_count_out <= '0;
      else if (retry_inc)  retry_count_out <= retry_count_out + 2'd1;
      // The timeout starts at the grant so it covers the frame's serial time.
      if (send_grant) timeout_q <= TO_LOAD;
      else if ((state_q == WAIT_ACK) && (timeout_q != '0)) timeout_q <= timeout_q - TO_W'(1);
    end
  end

  // Transmit arbiter registers: trigger pulse, frame byte and guard window.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tx_trigger_out <= 1'b0;
      tx_val_out     <= '0;
      guard_q        <= '0;
    end else begin
      tx_trigger_out <= ack_grant || send_grant;
      if (ack_grant)       tx_val_out <= {ack_seq_q, ACK_CODE};
      else if (send_grant) tx_val_out <= {tx_seq_q, move_q};
      // tx raises busy a cycle or two after the trigger; the guard covers that gap.
      if (ack_grant || send_grant) guard_q <= GD_LOAD;
      else if (guard_q != '0)      guard_q <= guard_q - GD_W'(1);
    end
  end

  // Receive-side registers: one-shot delivery and single pending ack slot.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_move_valid_out <= 1'b0;
      rx_move_out       <= '0;
      last_rx_seq_q     <= 1'b1;
      ack_pending_q     <= 1'b0;
      ack_seq_q         <= 1'b0;
    end else begin
      rx_move_valid_out <= rx_new_move;
      if (rx_new_move) begin
        rx_move_out   <= rx_data_in[6:0];
        last_rx_seq_q <= rx_data_in[7];
      end
      // A fresh move re-arms the ack even if the old one is being granted now.
      if (rx_is_move) begin
        ack_pending_q <= 1'b1;
        ack_seq_q     <= rx_data_in[7];
      end else if (ack_grant) begin
        ack_pending_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_move_link_ctrl.sv
// Bench for move_link_ctrl: scoreboard queues of expected tx frames and
// remote deliveries, filled as stimulus is driven and drained by a monitor.
module tb_move_link_ctrl;

  localparam int TIMEOUT_CYC = 1000;
  localparam int MAX_RETRY   = 3;
  localparam int GUARD_CYC   = 2;
  localparam int BUSY_CYC    = 10;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       move_valid_in;
  logic [6:0] move_in;
  logic       tx_busy_in;
  logic       tx_trigger_out;
  logic [7:0] tx_val_out;
  logic       rx_ready_in;
  logic [7:0] rx_data_in;
  logic       rx_move_valid_out;
  logic [6:0] rx_move_out;
  logic       move_sent_out;
  logic       link_busy_out;
  logic       link_error_out;
  logic [1:0] retry_count_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_tx_q[$];
  logic [6:0] exp_rx_q[$];
  int trig_count  = 0;
  int sent_count  = 0;
  int deliv_count = 0;
  int cyc = 0;
  int last_trig_cyc = -1000;
  logic model_tx_seq = 1'b0;
  logic model_last_rx_seq = 1'b1;
  logic force_busy = 1'b0;
  int busy_left = 0;

  move_link_ctrl #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .MAX_RETRY  (MAX_RETRY),
    .GUARD_CYC  (GUARD_CYC)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .move_valid_in    (move_valid_in),
    .move_in          (move_in),
    .tx_busy_in       (tx_busy_in),
    .tx_trigger_out   (tx_trigger_out),
    .tx_val_out       (tx_val_out),
    .rx_ready_in      (rx_ready_in),
    .rx_data_in       (rx_data_in),
    .rx_move_valid_out(rx_move_valid_out),
    .rx_move_out      (rx_move_out),
    .move_sent_out    (move_sent_out),
    .link_busy_out    (link_busy_out),
    .link_error_out   (link_error_out),
    .retry_count_out  (retry_count_out)
  );

  always #5 clk_in = ~clk_in;

  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  // tx model: busy for BUSY_CYC cycles after each trigger, or held by force_busy.
  initial begin
    tx_busy_in = 1'b0;
    forever begin
      @(negedge clk_in);
      if (!rst_in)             busy_left = 0;
      else if (tx_trigger_out) busy_left = BUSY_CYC;
      else if (busy_left > 0)  busy_left--;
      tx_busy_in = force_busy || (busy_left > 0);
    end
  end

  // Monitor: pops the scoreboard on each trigger / delivery.
  initial begin
    logic [7:0] exp_b;
    logic [6:0] exp_m;
    int gap;
    forever begin
      @(negedge clk_in);
      if (tx_trigger_out) begin
        trig_count++;
        gap = cyc - last_trig_cyc;
        last_trig_cyc = cyc;
        checks++;
        if (gap <= GUARD_CYC) begin
          errors++;
          $display("FAIL trigger_spacing: gap %0d cycles, required > %0d", gap, GUARD_CYC);
        end
        checks++;
        if (exp_tx_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_trigger: tx_val_out=%h, required no trigger", tx_val_out);
        end else begin
          exp_b = exp_tx_q.pop_front();
          if (tx_val_out !== exp_b) begin
            errors++;
            $display("FAIL tx_frame: got %h, expected %h", tx_val_out, exp_b);
          end
        end
      end
      if (rx_move_valid_out) begin
        deliv_count++;
        checks++;
        if (exp_rx_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_delivery: rx_move_out=%0d, required no delivery", rx_move_out);
        end else begin
          exp_m = exp_rx_q.pop_front();
          if (rx_move_out !== exp_m) begin
            errors++;
            $display("FAIL rx_delivery: got %0d, expected %0d", rx_move_out, exp_m);
          end
        end
      end
      if (move_sent_out) sent_count++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_move(input logic [6:0] m);
    move_valid_in = 1'b1;
    move_in       = m;
    @(negedge clk_in);
    move_valid_in = 1'b0;
  endtask

  // Model of the receive side: new seq -> delivery; every move -> ack.
  task automatic rx_expect(input logic [7:0] b);
    if (b[6:0] != 7'h7F) begin
      if (b[7] != model_last_rx_seq) begin
        exp_rx_q.push_back(b[6:0]);
        model_last_rx_seq = b[7];
      end
      exp_tx_q.push_back({b[7], 7'h7F});
    end
  endtask

  task automatic drive_rx(input logic [7:0] b);
    rx_expect(b);
    rx_ready_in = 1'b1;
    rx_data_in  = b;
    @(negedge clk_in);
    rx_ready_in = 1'b0;
  endtask

  task automatic wait_trig(input int budget, input string name);
    int start;
    bit seen;
    start = trig_count;
    seen  = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_in);
      if (trig_count != start) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: no tx trigger within %0d cycles", name, budget);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_in = 1'b0;
    move_valid_in = 1'b1; move_in = 7'd40;
    rx_ready_in = 1'b1;   rx_data_in = 8'h05;
    repeat (3) @(negedge clk_in);
    checks++;
    if ({tx_trigger_out, tx_val_out, rx_move_valid_out, rx_move_out, move_sent_out,
         link_busy_out, link_error_out, retry_count_out} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got trig=%b val=%h rxv=%b rxm=%0d sent=%b busy=%b err=%b retry=%0d, expected all 0",
               tx_trigger_out, tx_val_out, rx_move_valid_out, rx_move_out, move_sent_out,
               link_busy_out, link_error_out, retry_count_out);
    end
    move_valid_in = 1'b0;
    rx_ready_in   = 1'b0;
    rst_in        = 1'b1;
    repeat (3) @(negedge clk_in);
    checks++;
    if (link_busy_out !== 1'b0 || trig_count != 0 || deliv_count != 0) begin
      errors++;
      $display("FAIL reset_release: busy=%b triggers=%0d deliveries=%0d, expected 0/0/0",
               link_busy_out, trig_count, deliv_count);
    end
  endtask

  task automatic test_local_move();
    int s0;
    s0 = sent_count;
    exp_tx_q.push_back(8'h28);
    drive_move(7'd40);
    checks++;
    if (link_busy_out !== 1'b1 || tx_trigger_out !== 1'b0) begin
      errors++;
      $display("FAIL accept_latency: busy=%b trig=%b, expected busy=1 trig=0", link_busy_out, tx_trigger_out);
    end
    @(negedge clk_in);
    checks++;
    if (tx_trigger_out !== 1'b1) begin
      errors++;
      $display("FAIL trigger_latency: trig=%b two cycles after move_valid_in, expected 1", tx_trigger_out);
    end
    repeat (BUSY_CYC + 5) @(negedge clk_in);
    drive_rx(8'h7F);
    checks++;
    if (move_sent_out !== 1'b1 || link_busy_out !== 1'b0) begin
      errors++;
      $display("FAIL ack_accept: sent=%b busy=%b, expected sent=1 busy=0", move_sent_out, link_busy_out);
    end
    model_tx_seq = ~model_tx_seq;
    @(negedge clk_in);
    checks++;
    if (move_sent_out !== 1'b0 || sent_count != s0 + 1) begin
      errors++;
      $display("FAIL sent_pulse_width: sent=%b count=%0d, expected 0 and %0d", move_sent_out, sent_count, s0 + 1);
    end
    exp_tx_q.push_back(8'hA9);
    drive_move(7'd41);
    wait_trig(10, "second_move_trigger");
    repeat (BUSY_CYC + 5) @(negedge clk_in);
    drive_rx(8'hFF);
    checks++;
    if (move_sent_out !== 1'b1) begin
      errors++;
      $display("FAIL second_ack: sent=%b, expected 1", move_sent_out);
    end
    model_tx_seq = ~model_tx_seq;
    @(negedge clk_in);
  endtask

  task automatic test_remote_move();
    int d0;
    drive_rx(8'h05);
    checks++;
    if (rx_move_valid_out !== 1'b1 || rx_move_out !== 7'd5) begin
      errors++;
      $display("FAIL remote_delivery: valid=%b move=%0d, expected 1 and 5", rx_move_valid_out, rx_move_out);
    end
    @(negedge clk_in);
    checks++;
    if (tx_trigger_out !== 1'b1) begin
      errors++;
      $display("FAIL ack_trigger_latency: trig=%b, expected 1", tx_trigger_out);
    end
    repeat (BUSY_CYC + 4) @(negedge clk_in);
    d0 = deliv_count;
    drive_rx(8'h05);
    checks++;
    if (rx_move_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL duplicate_delivered: valid=%b, expected 0", rx_move_valid_out);
    end
    wait_trig(20, "duplicate_reack");
    checks++;
    if (deliv_count != d0 || rx_move_out !== 7'd5) begin
      errors++;
      $display("FAIL duplicate_hold: deliveries=%0d move=%0d, expected %0d and 5", deliv_count, rx_move_out, d0);
    end
    repeat (BUSY_CYC + 4) @(negedge clk_in);
  endtask

  task automatic test_wrong_seq();
    exp_tx_q.push_back({model_tx_seq, 7'd7});
    exp_tx_q.push_back({model_tx_seq, 7'd7});
    drive_move(7'd7);
    wait_trig(10, "wrong_seq_first_send");
    repeat (BUSY_CYC + 5) @(negedge clk_in);
    drive_rx({~model_tx_seq, 7'h7F});
    checks++;
    if (move_sent_out !== 1'b0) begin
      errors++;
      $display("FAIL wrong_seq_ack_taken: sent=%b, expected 0", move_sent_out);
    end
    wait_trig(TIMEOUT_CYC + 50, "wrong_seq_retransmit");
    checks++;
    if (retry_count_out !== 2'd1) begin
      errors++;
      $display("FAIL wrong_seq_retry: retry=%0d, expected 1", retry_count_out);
    end
    repeat (BUSY_CYC + 5) @(negedge clk_in);
    drive_rx({model_tx_seq, 7'h7F});
    checks++;
    if (move_sent_out !== 1'b1) begin
      errors++;
      $display("FAIL right_seq_ack: sent=%b, expected 1", move_sent_out);
    end
    model_tx_seq = ~model_tx_seq;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_simultaneous();
    logic [7:0] b;
    b = {~model_last_rx_seq, 7'd5};
    rx_expect(b);
    exp_tx_q.push_back({model_tx_seq, 7'd9});
    move_valid_in = 1'b1; move_in = 7'd9;
    rx_ready_in   = 1'b1; rx_data_in = b;
    @(negedge clk_in);
    move_valid_in = 1'b0;
    rx_ready_in   = 1'b0;
    checks++;
    if (rx_move_valid_out !== 1'b1 || link_busy_out !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_accept: rxv=%b busy=%b, expected 1/1", rx_move_valid_out, link_busy_out);
    end
    wait_trig(20, "same_cycle_ack");
    wait_trig(40, "same_cycle_move");
    repeat (BUSY_CYC + 5) @(negedge clk_in);
    drive_rx({model_tx_seq, 7'h7F});
    checks++;
    if (move_sent_out !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_sent: sent=%b, expected 1", move_sent_out);
    end
    model_tx_seq = ~model_tx_seq;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_arbitration();
    int s;
    force_busy = 1'b1;
    repeat (2) @(negedge clk_in);
    s = trig_count;
    drive_move(7'd3);
    repeat (4) @(negedge clk_in);
    checks++;
    if (trig_count != s || link_busy_out !== 1'b1) begin
      errors++;
      $display("FAIL send_while_busy: triggers=%0d busy=%b, expected %0d and 1", trig_count, link_busy_out, s);
    end
    drive_rx({~model_last_rx_seq, 7'h10});
    exp_tx_q.push_back({model_tx_seq, 7'd3});
    repeat (4) @(negedge clk_in);
    checks++;
    if (trig_count != s) begin
      errors++;
      $display("FAIL ack_while_busy: triggers=%0d, expected %0d", trig_count, s);
    end
    force_busy = 1'b0;
    wait_trig(20, "arb_ack_first");
    wait_trig(40, "arb_move_second");
    repeat (BUSY_CYC + 5) @(negedge clk_in);
    drive_rx({model_tx_seq, 7'h7F});
    checks++;
    if (move_sent_out !== 1'b1) begin
      errors++;
      $display("FAIL arb_sent: sent=%b, expected 1", move_sent_out);
    end
    model_tx_seq = ~model_tx_seq;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_ack_lost();
    int t_prev;
    int gap;
    int s;
    for (int i = 0; i < MAX_RETRY + 1; i++) exp_tx_q.push_back({model_tx_seq, 7'd50});
    drive_move(7'd50);
    wait_trig(10, "lost_first_send");
    t_prev = last_trig_cyc;
    for (int r = 1; r <= MAX_RETRY; r++) begin
      wait_trig(TIMEOUT_CYC + 50, "lost_retransmit");
      gap = last_trig_cyc - t_prev;
      t_prev = last_trig_cyc;
      checks++;
      if (gap < TIMEOUT_CYC || gap > TIMEOUT_CYC + 20 || retry_count_out !== 2'(r)) begin
        errors++;
        $display("FAIL retransmit_%0d: gap=%0d retry=%0d, expected gap %0d..%0d retry=%0d",
                 r, gap, retry_count_out, TIMEOUT_CYC, TIMEOUT_CYC + 20, r);
      end
    end
    repeat (TIMEOUT_CYC + 20) @(negedge clk_in);
    checks++;
    if (link_error_out !== 1'b1 || link_busy_out !== 1'b1 || retry_count_out !== 2'd3) begin
      errors++;
      $display("FAIL error_state: err=%b busy=%b retry=%0d, expected 1/1/3", link_error_out, link_busy_out, retry_count_out);
    end
    s = trig_count;
    drive_move(7'd60);
    repeat (30) @(negedge clk_in);
    checks++;
    if (trig_count != s || link_error_out !== 1'b1) begin
      errors++;
      $display("FAIL error_sticky: triggers=%0d err=%b, expected %0d and 1", trig_count, link_error_out, s);
    end
  endtask

  task automatic test_reset_mid();
    int s_trig;
    int s_sent;
    rst_in = 1'b0;
    model_tx_seq = 1'b0;
    model_last_rx_seq = 1'b1;
    repeat (3) @(negedge clk_in);
    checks++;
    if (link_error_out !== 1'b0) begin
      errors++;
      $display("FAIL error_cleared_by_reset: err=%b, expected 0", link_error_out);
    end
    rst_in = 1'b1;
    @(negedge clk_in);
    exp_tx_q.push_back(8'h14);
    drive_move(7'd20);
    wait_trig(10, "pre_reset_send");
    repeat (BUSY_CYC + 5) @(negedge clk_in);
    @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    checks++;
    if ({tx_trigger_out, tx_val_out, rx_move_valid_out, rx_move_out, move_sent_out,
         link_busy_out, link_error_out, retry_count_out} !== 22'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b val=%h rxm=%0d err=%b retry=%0d, expected all 0 immediately",
               link_busy_out, tx_val_out, rx_move_out, link_error_out, retry_count_out);
    end
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    s_trig = trig_count;
    s_sent = sent_count;
    repeat (20) @(negedge clk_in);
    checks++;
    if (trig_count != s_trig || sent_count != s_sent) begin
      errors++;
      $display("FAIL pulse_after_reset: triggers=%0d sent=%0d, expected %0d and %0d", trig_count, sent_count, s_trig, s_sent);
    end
    exp_tx_q.push_back(8'h15);
    drive_move(7'd21);
    wait_trig(10, "post_reset_send");
    repeat (BUSY_CYC + 5) @(negedge clk_in);
    drive_rx(8'h7F);
    checks++;
    if (move_sent_out !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ack: sent=%b, expected 1", move_sent_out);
    end
    model_tx_seq = ~model_tx_seq;
    repeat (5) @(negedge clk_in);
  endtask

  initial begin
    rst_in        = 1'b0;
    move_valid_in = 1'b0;
    move_in       = '0;
    rx_ready_in   = 1'b0;
    rx_data_in    = '0;
    @(negedge clk_in);
    test_reset();
    test_local_move();
    test_remote_move();
    test_wrong_seq();
    test_simultaneous();
    test_arbitration();
    test_ack_lost();
    test_reset_mid();
    checks++;
    if (exp_tx_q.size() != 0 || exp_rx_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained: %0d tx frames and %0d deliveries still expected",
               exp_tx_q.size(), exp_rx_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
